bmp_pixel_writer: RTL and testbench
===================================

Name: bmp_pixel_writer

Overview:
- Downstream neighbour of the BMP header writer. After the 54-byte header is placed in output memory, this block streams the pixel array.
- It reads RGB pixels inside the bounding box [xMin,xMax) x [yMin,yMax) from the frame buffer and writes them bottom-up as B,G,R bytes, with each row padded to a 4-byte multiple.
- Writes go to the same byte-addressed output memory port style as the header writer, starting at address 54.

Parameters:
- FB_WIDTH, 640, frame buffer row pitch in pixels.
- FB_AW, 19, frame buffer address width.
- HDR_BYTES, 54, first output address for pixel data.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin transfer; sampled only in IDLE or DONE
- done  out  1  high while in DONE
- xMin, xMax, yMin, yMax  in  11 each  bounding box; max bounds exclusive; sampled on accepted start
- fb_addr  out  FB_AW  frame buffer read address
- fb_rden  out  1  frame buffer read strobe
- fb_rddata  in  24  pixel, valid the cycle after fb_rden; [23:16]=R, [15:8]=G, [7:0]=B
- addr  out  24  output memory byte address
- wren  out  1  output write enable
- wrdata  out  16  byte in [7:0]; [15:8] always 0

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0. Reset mid-transfer aborts immediately with no further writes.
- Geometry latched on accepted start:
  - W = xMax - xMin; H = yMax - yMin, 11-bit unsigned.
  - If xMax <= xMin or yMax <= yMin, the box is empty.
  - pad = W[1:0], which equals (4 - 3W mod 4) mod 4.
- States: IDLE, FETCH, WR_B, WR_G, WR_R, PAD, DONE.
- IDLE/DONE + start:
  - Empty box: go to DONE next cycle, zero writes.
  - Otherwise: y = yMax-1, x = xMin, out_addr = HDR_BYTES, go to FETCH.
- start while busy (FETCH..PAD) is ignored.
- FETCH:
  - fb_rden = 1, fb_addr = y*FB_WIDTH + x, truncated to FB_AW bits.
  - wren = 0. Next state WR_B.
- WR_B:
  - Capture fb_rddata into the pixel register.
  - wren = 1, addr = out_addr, wrdata = {8'h00, B}; out_addr++.
- WR_G: same pattern, writes G.
- WR_R: same pattern, writes R, then:
  - x != xMax-1: x++, go to FETCH.
  - else if pad != 0: go to PAD with pad_cnt = pad.
  - else: end of row.
- PAD:
  - Each cycle one beat: wren = 1, wrdata = 0, out_addr++, pad_cnt--.
  - When the last pad beat is written, end of row.
- End of row:
  - y == yMin: go to DONE.
  - else: y--, x = xMin, go to FETCH.
- addr, wren and wrdata are valid in the same cycle as the state listed. wren = 0 in IDLE, FETCH and DONE.
- Latency: with start accepted at cycle 0, done rises at cycle 1 + H*(4W + pad).
  - Total write beats = H*(3W + pad), at consecutive addresses HDR_BYTES onward.
- done:
  - Held high in DONE until the next accepted start.
  - Drops the cycle after start is accepted.
  - Never high in IDLE after reset.
- fb_rden is high only in FETCH.
- Maximum address 54 + 2047*(3*2047+3) fits in 24 bits, so no wrap handling is required.
- fb_addr beyond the frame buffer is the caller's responsibility; it is truncated, not checked.

Decomposition:
- Shared package bmp_pkg:
  - HDR_BYTES = 54, BYTES_PER_PIXEL = 3.
  - pixel_state_t enum.
  - pad_bytes(width) function returning width[1:0].
  - The header writer also uses this package.
- One natural sub-module, bmp_scan_counter: x/y/pad counters with row-end and last-row flags.
  - It owns the latched bounds and exposes fb_addr computation.

Test Plan:
- Box (0,2)x(0,1), FB pixels 0x112233 and 0x445566, start at cycle 0:
  - 8 beats at addr 54..61: 33,22,11,66,55,44,00,00.
  - done rises at cycle 11.
- Box (10,13)x(5,7), FB_WIDTH=640:
  - First fb_addr = 6*640+10 = 3850; row 5 follows with first fb_addr 3210.
  - 24 beats total at 54..77, pad 3 per row.
  - done at cycle 1 + 2*15 = 31.
- Box (4,8)x(0,1), W=4:
  - pad 0; 12 beats, no zero beats.
  - done at cycle 17.
- Empty box xMin=xMax=7:
  - wren never asserted, fb_rden never asserted.
  - done high at cycle 1.
- Reset at cycle 5 of a 2x2 transfer:
  - Next cycle wren=0, done=0, state IDLE.
  - A new start restarts writes at addr 54.
- start pulsed during WR_G is ignored.
  - After done, a second start with a new box drops done the next cycle and reproduces the correct byte sequence.

Source files
------------

// File: rtl/bmp_pkg.sv
// Types and constants shared by the BMP header writer and the pixel writer.
package bmp_pkg;
  localparam int HDR_BYTES       = 54;
  localparam int BYTES_PER_PIXEL = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WR_B, S_WR_G, S_WR_R, S_PAD, S_DONE
  } pixel_state_t;

  // W[1:0] == (4 - 3W mod 4) mod 4, because 3W mod 4 == -W mod 4.
  function automatic logic [1:0] pad_bytes(input logic [10:0] width);
    return width[1:0];
  endfunction
endpackage

// File: rtl/bmp_scan_counter.sv
// Bounding-box scan position (x, y, pad) with row/column flags and frame-buffer address.
module bmp_scan_counter #(
  parameter int FB_WIDTH = 640,
  parameter int FB_AW    = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             col_step,
  input  logic             row_step,
  input  logic             pad_load,
  input  logic             pad_step,
  input  logic [10:0]      x_min_in,
  input  logic [10:0]      x_max_in,
  input  logic [10:0]      y_min_in,
  input  logic [10:0]      y_max_in,
  output logic             empty,
  output logic             last_col,
  output logic             last_row,
  output logic             pad_zero,
  output logic             pad_last,
  output logic [FB_AW-1:0] fb_addr
);
  import bmp_pkg::*;

  logic [10:0] x_min, x_max, y_min;
  logic [10:0] x, y;
  logic [1:0]  pad, pad_cnt;
  logic [10:0] w_in;

  assign w_in  = x_max_in - x_min_in;
  assign empty = (x_max_in <= x_min_in) || (y_max_in <= y_min_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_min   <= '0;
      x_max   <= '0;
      y_min   <= '0;
      x       <= '0;
      y       <= '0;
      pad     <= '0;
      pad_cnt <= '0;
    end else begin
      if (load) begin
        x_min <= x_min_in;
        x_max <= x_max_in;
        y_min <= y_min_in;
        x     <= x_min_in;
        y     <= y_max_in - 11'd1;
        pad   <= pad_bytes(w_in);
      end else if (row_step) begin
        x <= x_min;
        y <= y - 11'd1;
      end else if (col_step) begin
        x <= x + 11'd1;
      end
      if (pad_load)      pad_cnt <= pad;
      else if (pad_step) pad_cnt <= pad_cnt - 2'd1;
    end
  end

  assign last_col = (x == x_max - 11'd1);
  assign last_row = (y == y_min);
  assign pad_zero = (pad == 2'd0);
  assign pad_last = (pad_cnt == 2'd1);

  // Arithmetic done modulo 2^FB_AW: out-of-range addresses simply wrap.
  assign fb_addr = FB_AW'(y) * FB_AW'(FB_WIDTH) + FB_AW'(x);
endmodule

// File: rtl/bmp_pixel_writer.sv
// Streams the bounding-box pixels bottom-up as padded B,G,R bytes after the BMP header.
module bmp_pixel_writer #(
  parameter int FB_WIDTH  = 640,
  parameter int FB_AW     = 19,
  parameter int HDR_BYTES = bmp_pkg::HDR_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             done,
  input  logic [10:0]      xMin,
  input  logic [10:0]      xMax,
  input  logic [10:0]      yMin,
  input  logic [10:0]      yMax,
  output logic [FB_AW-1:0] fb_addr,
  output logic             fb_rden,
  input  logic [23:0]      fb_rddata,
  output logic [23:0]      addr,
  output logic             wren,
  output logic [15:0]      wrdata
);
  import bmp_pkg::*;

  pixel_state_t state, state_nxt;
  logic [23:0]  out_addr;
  logic [15:0]  pix_rg;
  logic         empty, last_col, last_row, pad_zero, pad_last;
  logic         load, col_step, row_step, pad_load, pad_step, idle_like;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);

  bmp_scan_counter #(.FB_WIDTH(FB_WIDTH), .FB_AW(FB_AW)) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .col_step (col_step),
    .row_step (row_step),
    .pad_load (pad_load),
    .pad_step (pad_step),
    .x_min_in (xMin),
    .x_max_in (xMax),
    .y_min_in (yMin),
    .y_max_in (yMax),
    .empty    (empty),
    .last_col (last_col),
    .last_row (last_row),
    .pad_zero (pad_zero),
    .pad_last (pad_last),
    .fb_addr  (fb_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      out_addr <= '0;
      pix_rg   <= '0;
    end else begin
      state <= state_nxt;
      if (load)      out_addr <= 24'(HDR_BYTES);
      else if (wren) out_addr <= out_addr + 24'd1;
      if (state == S_WR_B) pix_rg <= fb_rddata[23:8];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = empty ? S_DONE : S_FETCH;
      S_FETCH: state_nxt = S_WR_B;
      S_WR_B:  state_nxt = S_WR_G;
      S_WR_G:  state_nxt = S_WR_R;
      S_WR_R: begin
        if (!last_col)      state_nxt = S_FETCH;
        else if (!pad_zero) state_nxt = S_PAD;
        else                state_nxt = last_row ? S_DONE : S_FETCH;
      end
      S_PAD: if (pad_last) state_nxt = last_row ? S_DONE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done     = (state == S_DONE);
    fb_rden  = (state == S_FETCH);
    wren     = 1'b0;
    wrdata   = 16'h0000;
    load     = idle_like && start && !empty;
    col_step = (state == S_WR_R) && !last_col;
    pad_load = (state == S_WR_R) && last_col && !pad_zero;
    pad_step = (state == S_PAD);
    row_step = !last_row &&
               (((state == S_WR_R) && last_col && pad_zero) ||
                ((state == S_PAD) && pad_last));
    case (state)
      S_WR_B: begin wren = 1'b1; wrdata = {8'h00, fb_rddata[7:0]}; end
      S_WR_G: begin wren = 1'b1; wrdata = {8'h00, pix_rg[7:0]};    end
      S_WR_R: begin wren = 1'b1; wrdata = {8'h00, pix_rg[15:8]};   end
      S_PAD:  wren = 1'b1;
      default: ;
    endcase
  end

  assign addr = out_addr;
endmodule

// File: tb/tb_bmp_pixel_writer.sv
// Directed and random bounding boxes checked against a byte-stream reference model.
module tb_bmp_pixel_writer;
  localparam int FBW = 640;
  localparam int AW  = 19;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [10:0]   xMin = '0, xMax = '0, yMin = '0, yMax = '0;
  logic          done, fb_rden, wren;
  logic [AW-1:0] fb_addr;
  logic [23:0]   fb_rddata = '0;
  logic [23:0]   addr;
  logic [15:0]   wrdata;
  int            tests = 0, fails = 0;

  always #5 clk = ~clk;

  bmp_pixel_writer #(.FB_WIDTH(FBW), .FB_AW(AW), .HDR_BYTES(54)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .fb_addr(fb_addr), .fb_rden(fb_rden), .fb_rddata(fb_rddata),
    .addr(addr), .wren(wren), .wrdata(wrdata)
  );

  function automatic logic [23:0] pix_of(input logic [AW-1:0] a);
    if (a == 0) return 24'h112233;
    if (a == 1) return 24'h445566;
    return 24'((32'(a) * 32'h9E3779B1) >> 5);
  endfunction

  // Frame buffer: one-cycle read latency; junk when not read.
  always @(posedge clk) fb_rddata <= fb_rden ? pix_of(fb_addr) : 24'hDEAD00;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_box(input string tag, input int x0, input int x1,
                         input int y0, input int y1, input int pulse_cyc);
    logic [39:0]   exp_beats[$], got_beats[$];
    logic [AW-1:0] exp_rd[$], got_rd[$];
    logic [23:0]   p;
    int w, h, pad, exp_done, done_cyc, n;
    bit emp;
    emp = (x1 <= x0) || (y1 <= y0);
    exp_done = 1;
    if (!emp) begin
      w = x1 - x0;
      h = y1 - y0;
      pad = (4 - (3 * w) % 4) % 4;
      for (int r = y1 - 1; r >= y0; r--) begin
        for (int c = x0; c < x1; c++) begin
          exp_rd.push_back(AW'((r * FBW + c) % (1 << AW)));
          p = pix_of(AW'((r * FBW + c) % (1 << AW)));
          exp_beats.push_back({24'(54 + exp_beats.size()), 8'h00, p[7:0]});
          exp_beats.push_back({24'(54 + exp_beats.size()), 8'h00, p[15:8]});
          exp_beats.push_back({24'(54 + exp_beats.size()), 8'h00, p[23:16]});
        end
        repeat (pad) exp_beats.push_back({24'(54 + exp_beats.size()), 16'h0000});
      end
      exp_done = 1 + h * (4 * w + pad);
    end

    @(posedge clk); #1;
    start = 1'b1;
    xMin = 11'(x0); xMax = 11'(x1); yMin = 11'(y0); yMax = 11'(y1);
    @(posedge clk); #1;
    done_cyc = -1;
    for (int cyc = 1; cyc <= exp_done + 20; cyc++) begin
      if (cyc == pulse_cyc) begin
        start = 1'b1;
        xMin = 11'd0; xMax = 11'd5; yMin = 11'd0; yMax = 11'd5;
      end else start = 1'b0;
      @(negedge clk);
      if (wren)    got_beats.push_back({addr, wrdata});
      if (fb_rden) got_rd.push_back(fb_addr);
      if (done) begin done_cyc = cyc; break; end
      @(posedge clk); #1;
    end
    start = 1'b0;

    check({tag, "_done_cycle"}, 48'(done_cyc), 48'(exp_done));
    check({tag, "_beat_count"}, 48'(got_beats.size()), 48'(exp_beats.size()));
    check({tag, "_read_count"}, 48'(got_rd.size()), 48'(exp_rd.size()));
    n = (got_beats.size() < exp_beats.size()) ? got_beats.size() : exp_beats.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_beat%0d", tag, i), 48'(got_beats[i]), 48'(exp_beats[i]));
    n = (got_rd.size() < exp_rd.size()) ? got_rd.size() : exp_rd.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_fbaddr%0d", tag, i), 48'(got_rd[i]), 48'(exp_rd[i]));
  endtask

  initial begin
    int x0, y0, w, h;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_done",    48'(done),    48'd0);
    check("rst_wren",    48'(wren),    48'd0);
    check("rst_fb_rden", 48'(fb_rden), 48'd0);
    check("rst_addr",    48'(addr),    48'd0);
    check("rst_wrdata",  48'(wrdata),  48'd0);
    check("rst_fb_addr", 48'(fb_addr), 48'd0);
    repeat (3) @(negedge clk);
    check("idle_done_low", 48'(done), 48'd0);

    run_box("two_px",  0, 2, 0, 1, 0);
    run_box("box3x2", 10, 13, 5, 7, 0);
    run_box("w4_nopad", 4, 8, 0, 1, 0);
    run_box("empty_x", 7, 7, 0, 3, 0);
    run_box("empty_y", 2, 9, 4, 4, 0);

    // Synchronous reset asserted during cycle 5 of a 2x2 transfer.
    @(posedge clk); #1;
    start = 1'b1; xMin = 11'd0; xMax = 11'd2; yMin = 11'd0; yMax = 11'd2;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_wren",    48'(wren),    48'd0);
    check("abort_done",    48'(done),    48'd0);
    check("abort_fb_rden", 48'(fb_rden), 48'd0);
    check("abort_addr",    48'(addr),    48'd0);
    run_box("after_rst", 0, 2, 0, 2, 0);

    run_box("pulse_wrg", 1, 4, 2, 4, 3);
    run_box("second",    5, 6, 1, 4, 0);
    run_box("trunc",     3, 5, 900, 902, 0);

    for (int k = 0; k < 8; k++) begin
      x0 = $urandom_range(0, 630);
      y0 = $urandom_range(0, 2040);
      w  = $urandom_range(0, 6);
      h  = $urandom_range(1, 3);
      run_box($sformatf("rnd%0d", k), x0, x0 + w, y0, y0 + h, $urandom_range(0, 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
